// File: rtl/cw305_burst_reader.sv
// cw305_burst_reader: OBI read initiator that streams len words from base into a show-ahead FIFO.
module cw305_burst_reader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             req_o,
  input  logic             gnt_i,
  output logic [31:0]      addr_o,
  output logic             we_o,
  output logic [3:0]       be_o,
  input  logic             rvalid_i,
  input  logic [31:0]      rdata_i,
  output logic             rd_valid,
  output logic [31:0]      rd_data,
  input  logic             rd_ready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] req_left_q;
  logic [LEN_W-1:0] rsp_left_q;
  logic [LEN_W-1:0] rsp_left_d;
  logic [CW-1:0]    outst_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [CW:0]      inflight;
  logic             accept;
  logic             credit;
  logic             fire;
  logic             push;
  logic             pop;
  logic             full;

  // Request/response bookkeeping, FIFO flags and next state.
  // outst+count only falls between grants, so once the credit test passes it
  // stays true until the grant: a raised request cannot be withdrawn.
  always_comb begin
    accept     = (state_q == IDLE) && start;
    inflight   = {1'b0, outst_q} + {1'b0, count_q};
    credit     = inflight < (CW+1)'(FIFO_DEPTH);
    req_o      = (state_q == RUN) && (req_left_q != '0) && credit;
    fire       = req_o && gnt_i;
    push       = (state_q == RUN) && rvalid_i && (outst_q != '0);
    rd_valid   = count_q != '0;
    pop        = rd_valid && rd_ready;
    full       = count_q == CW'(FIFO_DEPTH);
    count_d    = count_q + CW'(push) - CW'(pop);
    rsp_left_d = rsp_left_q - LEN_W'(push);
    busy       = state_q == RUN;
    done       = state_q == FIN;
    addr_o     = addr_q;
    we_o       = 1'b0;
    be_o       = 4'hF;
    rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;

    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (len == '0) ? FIN : RUN;
      RUN:  if ((rsp_left_d == '0) && (count_d == '0)) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Address and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      req_left_q <= '0;
      rsp_left_q <= '0;
      outst_q    <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      if (accept && (len != '0)) begin
        addr_q     <= base_addr & 32'hFFFF_FFFC;
        req_left_q <= len;
        rsp_left_q <= len;
      end else begin
        if (fire) begin
          addr_q     <= addr_q + 32'd4;
          req_left_q <= req_left_q - LEN_W'(1);
        end
        rsp_left_q <= rsp_left_d;
      end
      outst_q <= outst_q + CW'(fire) - CW'(push);
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rdata_i;
  end

  // A push into a full FIFO means the credit rule was broken.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && full));
  end

endmodule

// File: tb/tb_cw305_burst_reader.sv
// tb_cw305_burst_reader: randomized OBI slave and host against a burst-level reference model.
module tb_cw305_burst_reader;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   base_addr;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic          req_o;
  logic          gnt_i;
  logic [31:0]   addr_o;
  logic          we_o;
  logic [3:0]    be_o;
  logic          rvalid_i;
  logic [31:0]   rdata_i;
  logic          rd_valid;
  logic [31:0]   rd_data;
  logic          rd_ready;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [31:0] rsp_data_q [$];
  int          rsp_rdy_q  [$];
  logic [31:0] exp_q      [$];

  cw305_burst_reader #(
    .FIFO_DEPTH(DEPTH),
    .LEN_W     (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .req_o    (req_o),
    .gnt_i    (gnt_i),
    .addr_o   (addr_o),
    .we_o     (we_o),
    .be_o     (be_o),
    .rvalid_i (rvalid_i),
    .rdata_i  (rdata_i),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_ready (rd_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // One burst: the bench plays OBI slave and host; expectations come from base/len alone.
  task automatic run_burst(input logic [31:0] b, input int l, input int gnt_pct,
                           input int rv_pct, input int rdy_pct, input int gnt_hold,
                           input int rdy_hold, input bit glitch);
    int          grants;
    int          resps;
    int          pops;
    bit          last_pop;
    bit          finished;
    logic [31:0] base_al;
    base_al = b & 32'hFFFF_FFFC;
    exp_q.delete();
    rsp_data_q.delete();
    rsp_rdy_q.delete();
    for (int i = 0; i < l; i++) exp_q.push_back(mem_word(base_al + 32'(4 * i)));
    grants = 0; resps = 0; pops = 0; last_pop = 0; finished = 0;

    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    start = 1'b1; base_addr = b; len = LW'(l);
    gnt_i = 1'b0; rvalid_i = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; base_addr = $urandom; len = LW'($urandom);
    if (l == 0) begin
      chk("zl_done", 32'(done), 32'd1);
      chk("zl_busy", 32'(busy), 32'd0);
      chk("zl_req", 32'(req_o), 32'd0);
      @(negedge clk);
      chk("zl_done_off", 32'(done), 32'd0);
      chk("zl_busy_off", 32'(busy), 32'd0);
      chk("zl_req_off", 32'(req_o), 32'd0);
      return;
    end
    chk("start_busy", 32'(busy), 32'd1);

    for (int k = 0; k < 4000 && !finished; k++) begin
      if (k > 0) @(negedge clk);
      chk("done", 32'(done), 32'(last_pop));
      if (last_pop) begin
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_req", 32'(req_o), 32'd0);
        chk("end_grants", 32'(grants), 32'(l));
        finished = 1;
      end else begin
        chk("busy", 32'(busy), 32'd1);
        chk("req", 32'(req_o), 32'((grants < l) && (grants - pops < int'(DEPTH))));
        if (req_o) chk("addr", addr_o, base_al + 32'(4 * grants));
        chk("rd_valid", 32'(rd_valid), 32'(resps != pops));
        if (rdy_hold > 0 && k + 1 == rdy_hold)
          chk("hold_grants", 32'(grants), 32'((l < int'(DEPTH)) ? l : int'(DEPTH)));

        start = glitch && (k == 2);
        if (start) begin base_addr = ~b; len = LW'(1); end

        gnt_i = req_o && (k >= gnt_hold) && (int'($urandom % 100) < gnt_pct);
        if (gnt_i) begin
          rsp_data_q.push_back(mem_word(addr_o));
          rsp_rdy_q.push_back(cyc + 1);
          grants++;
        end

        rvalid_i = 1'b0;
        rdata_i  = $urandom;
        if (rsp_rdy_q.size() > 0 && rsp_rdy_q[0] <= cyc && int'($urandom % 100) < rv_pct) begin
          rvalid_i = 1'b1;
          rdata_i  = rsp_data_q.pop_front();
          void'(rsp_rdy_q.pop_front());
          resps++;
        end

        rd_ready = (k >= rdy_hold) && (int'($urandom % 100) < rdy_pct);
        if (rd_valid && rd_ready) begin
          if (exp_q.size() == 0) chk("extra_word", 32'(rd_valid), 32'd0);
          else                   chk("rdata", rd_data, exp_q.pop_front());
          pops++;
          last_pop = (pops == l);
        end
      end
    end
    if (!finished) chk("timeout", 32'(done), 32'd1);
    start = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_req"},      32'(req_o),    32'd0);
    chk({tag, "_addr"},     addr_o,        32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data"},  rd_data,       32'd0);
    chk({tag, "_we"},       32'(we_o),     32'd0);
    chk({tag, "_be"},       32'(be_o),     32'hF);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0; rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rst = 1'b0;

    run_burst(32'h0000_1000, 3, 100, 100, 100, 0, 0, 1'b0);
    run_burst(32'h0000_4000, 8, 100, 100, 100, 0, 15, 1'b0);
    run_burst(32'hFFFF_FFFB, 3, 100, 100, 100, 0, 0, 1'b0);
    run_burst(32'h0000_5000, 4, 100, 100, 100, 5, 0, 1'b1);
    run_burst(32'h0000_6000, 0, 100, 100, 100, 0, 0, 1'b0);

    // Reset in the middle of a burst: two grants, one response buffered, one outstanding.
    @(negedge clk);
    start = 1'b1; base_addr = 32'h0000_2000; len = LW'(6);
    @(negedge clk);
    start = 1'b0;
    chk("mr_req0", 32'(req_o), 32'd1);
    chk("mr_addr0", addr_o, 32'h0000_2000);
    gnt_i = 1'b1;
    @(negedge clk);
    chk("mr_addr1", addr_o, 32'h0000_2004);
    gnt_i = 1'b1; rvalid_i = 1'b1; rdata_i = 32'hDEAD_0001;
    @(negedge clk);
    gnt_i = 1'b0; rvalid_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("mr");
    rvalid_i = 1'b1; rdata_i = 32'hDEAD_0002;
    @(negedge clk);
    rvalid_i = 1'b0;
    chk("mr_late_rvalid", 32'(rd_valid), 32'd0);
    chk("mr_late_busy", 32'(busy), 32'd0);
    run_burst(32'h0000_3000, 5, 100, 100, 100, 0, 0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      run_burst($urandom, int'($urandom_range(1, 20)), int'($urandom_range(30, 100)),
                int'($urandom_range(30, 100)), int'($urandom_range(20, 100)), 0, 0, 1'b0);
    end
    run_burst(32'hFFFF_FFF0, 9, 60, 70, 50, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cw305_burst_reader.md
# cw305_burst_reader

Readback engine for the CW305 bridge: fetches `len` consecutive 32-bit words from X-HEEP memory, starting at a word-aligned base address and stepping by 4, as an OBI read initiator. It buffers the returned data in a small FIFO and presents it to the host-side register logic through a valid/ready stream. It is the read-direction counterpart of the bridge's write path, which loads memory through an auto-incrementing +4 address counter.

## Interface
- `FIFO_DEPTH`, 4: readback FIFO entries; power of two, ≥2.
- `LEN_W`, 16: width of the word-count input.

Ports:
- `clk`  in  1  sole clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a burst when idle.
- `base_addr`  in  32  first word address; bits [1:0] ignored (treated as 00).
- `len`  in  LEN_W  number of words to read; sampled with `start`.
- `busy`  out  1  high from accepted `start` until the burst completes.
- `done`  out  1  one-cycle completion pulse.
- `req_o`  out  1  OBI request.
- `gnt_i`  in  1  OBI grant.
- `addr_o`  out  32  OBI address, always word aligned.
- `we_o`  out  1  constant 0.
- `be_o`  out  4  constant 4'hF.
- `rvalid_i`  in  1  OBI response valid.
- `rdata_i`  in  32  OBI read data.
- `rd_valid`  out  1  FIFO head valid toward host.
- `rd_data`  out  32  FIFO head word.
- `rd_ready`  in  1  host accepts head word.

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE: `start` with `len`≠0 latches `{base_addr[31:2],2'b00}` into the address counter and `len` into the remaining-request and remaining-response counters, then moves to RUN. `start` with `len`=0 moves to FIN with no bus traffic.
- `start` is ignored outside IDLE.
- RUN, request side:
  - Assert `req_o` while requests remain and `outstanding + fifo_count < FIFO_DEPTH`. This credit rule guarantees every response has a free FIFO slot.
  - Once asserted, `req_o` and `addr_o` hold stable until `gnt_i`; the credit rule must not drop a pending request.
  - On each `req_o && gnt_i`: address += 4 (mod 2^32, so 0xFFFFFFFC wraps to 0x00000000), requests remaining −1, outstanding +1.
- RUN, response side: each `rvalid_i` writes `rdata_i` to the FIFO, decrements outstanding, and decrements responses remaining. Grant and rvalid in the same cycle leave outstanding unchanged.
- FIFO: show-ahead. `rd_valid` = not empty; `rd_data` = head. A pop (`rd_valid && rd_ready`) and a push in the same cycle are both performed; count is unchanged. Overflow cannot occur; a push while full is a design error and is flagged by an assertion.
- RUN → FIN when responses remaining = 0 and the FIFO is empty after the current pop.
- FIN: `done` = 1 for one cycle, `busy` = 0, then return to IDLE.
- `rvalid_i` while in IDLE/FIN is ignored.
- `rst` at any time: FSM to IDLE, all counters and the FIFO cleared, pending request dropped. Responses to pre-reset requests are discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `req_o`=0, `addr_o`=0, `rd_valid`=0, `rd_data`=0; `we_o`=0 and `be_o`=4'hF always.
- `start` in cycle 0 → `busy`=1 and `req_o`=1 (if credit allows) in cycle 1, with `addr_o` = base.
- Zero-wait grants give one request per cycle, sustained as long as credit remains.
- `rvalid_i` in cycle n → `rd_valid`=1 in cycle n+1 (registered write).
- Last pop handshake in cycle m → `done`=1 and `busy`=0 in cycle m+1.
- `len`=0: `start` in cycle 0 → `done` in cycle 1, `busy` never asserted.

## Test plan
- Basic burst: base 0x0000_1000, len 3, gnt same cycle as req, rvalid 1 cycle later, `rd_ready`=1 → addresses 0x1000/0x1004/0x1008 in order, data delivered in order, one `done` pulse, `busy` low afterwards.
- Backpressure: len 8, FIFO_DEPTH 4, `rd_ready`=0 → exactly 4 grants then `req_o` low; raise `rd_ready` → remaining 4 issued; all 8 words delivered in order, no loss.
- Unaligned base and wrap: base 0xFFFF_FFFB, len 3 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Grant stall: hold `gnt_i`=0 for 5 cycles → `req_o` and `addr_o` stable for all 5; one transfer on the grant; `start` pulsed meanwhile is ignored.
- Zero length: `start` with len 0 → `done` next cycle, `req_o` never asserted.
- Mid-burst reset: `rst` after 2 of 6 grants with 1 response outstanding → all outputs return to reset values next cycle; a late `rvalid_i` is not pushed; a new burst afterwards runs correctly.
